// File: rtl/aer_in_rr_scheduler.sv
// aer_in_rr_scheduler
//   Round-robin merge of N_SRC AER event sources onto the single input port of
//   the LRF mapper. Sources handshake 4-phase. Accepted events go into a small
//   FIFO and are replayed to the mapper one at a time with its REQ/ACK handshake.
//
// Ports
//   clk                 clock
//   rst                 asynchronous reset, active low
//   SRC_AER_REQ         per-source request (4-phase)
//   SRC_AER_ADDR        per-source event {type[1:0], c, y, x}, stable while REQ high
//   SRC_AER_ACK         per-source acknowledge
//   MAP_IN_AERIN_REQ    request to the mapper
//   MAP_IN_AERIN_EVENT  {type, zeros}
//   MAP_IN_AERIN_IDX    {c, y, x}
//   MAP_IN_AERIN_ACK    acknowledge from the mapper
//   FIFO_LEVEL          current FIFO occupancy
//   BUSY                FIFO non-empty or output FSM not idle
//
// Optional build macro: AER_SCHED_BARRIER_EN
//   When defined, timestep markers (type 2'b10) are not forwarded directly.
//   Each marker masks its source; once every source is masked a single marker
//   is pushed and the mask clears.
//
// Source FSM
//   state    | meaning
//   S_IDLE   | waiting for REQ, eligible for arbitration
//   S_ACKED  | event captured, ACK high until REQ drops
//
// Output FSM
//   state     | meaning
//   O_IDLE    | waiting for a buffered event
//   O_SEND    | REQ high with head event, waiting for mapper ACK
//   O_RELEASE | REQ low, waiting for mapper ACK to drop
module aer_in_rr_scheduler #(
  parameter int N_SRC      = 2,
  parameter int AER_WIDTH  = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_SRC-1:0]              SRC_AER_REQ,
  input  logic [N_SRC*AER_WIDTH-1:0]    SRC_AER_ADDR,
  output logic [N_SRC-1:0]              SRC_AER_ACK,
  output logic                          MAP_IN_AERIN_REQ,
  output logic [AER_WIDTH-1:0]          MAP_IN_AERIN_EVENT,
  output logic [AER_WIDTH-3:0]          MAP_IN_AERIN_IDX,
  input  logic                          MAP_IN_AERIN_ACK,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic                          BUSY
);

  localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {S_IDLE, S_ACKED} src_state_t;
  typedef enum logic [1:0] {O_IDLE, O_SEND, O_RELEASE} out_state_t;

  src_state_t           r_src_state [N_SRC];
  src_state_t           w_src_nxt   [N_SRC];
  out_state_t           r_out_state;
  out_state_t           w_out_nxt;

  logic [PW-1:0]        r_rr_ptr;
  logic [N_SRC-1:0]     w_src_idle;
  logic [N_SRC-1:0]     w_elig;
  logic [PW-1:0]        w_cand;
  logic                 w_grant_vld;
  logic [PW-1:0]        w_grant_idx;
  logic                 w_grant;
  logic [AER_WIDTH-1:0] w_grant_addr;

  logic [AER_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [LW-1:0]        r_count;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic [AER_WIDTH-1:0] w_push_data;
  logic                 w_pop;
  logic                 w_load;
  logic [AER_WIDTH-1:0] r_out_data;

  assign w_full  = (r_count == LW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      w_src_idle[i]  = (r_src_state[i] == S_IDLE);
      SRC_AER_ACK[i] = (r_src_state[i] == S_ACKED);
    end
  end

  // Barrier mask handling
`ifdef AER_SCHED_BARRIER_EN
  logic [N_SRC-1:0] r_bar_mask;
  logic             w_is_marker;
  logic             w_bar_fire;

  assign w_is_marker = (w_grant_addr[AER_WIDTH-1 -: 2] == 2'b10);
  // With every source masked nothing is eligible, so this never collides
  // with a grant-driven push.
  assign w_bar_fire  = (&r_bar_mask) && !w_full;
  assign w_elig      = SRC_AER_REQ & w_src_idle & ~r_bar_mask;
  assign w_push      = (w_grant && !w_is_marker) || w_bar_fire;
  assign w_push_data = w_bar_fire ? {2'b10, {(AER_WIDTH-2){1'b0}}} : w_grant_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bar_mask <= '0;
    end else if (w_bar_fire) begin
      r_bar_mask <= '0;
    end else if (w_grant && w_is_marker) begin
      r_bar_mask[w_grant_idx] <= 1'b1;
    end
  end
`else
  assign w_elig      = SRC_AER_REQ & w_src_idle;
  assign w_push      = w_grant;
  assign w_push_data = w_grant_addr;
`endif

  // First eligible source at or after the pointer
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int k = 0; k < N_SRC; k++) begin
      w_cand = PW'((int'(r_rr_ptr) + k) % N_SRC);
      if (!w_grant_vld && w_elig[w_cand]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  // Full is taken from the registered count: a same-cycle pop does not free a slot.
  assign w_grant      = w_grant_vld && !w_full;
  assign w_grant_addr = SRC_AER_ADDR[w_grant_idx*AER_WIDTH +: AER_WIDTH];

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      w_src_nxt[i] = r_src_state[i];
      case (r_src_state[i])
        S_IDLE:  if (w_grant && (w_grant_idx == PW'(i))) w_src_nxt[i] = S_ACKED;
        S_ACKED: if (!SRC_AER_REQ[i]) w_src_nxt[i] = S_IDLE;
        default: w_src_nxt[i] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_SRC; i++) r_src_state[i] <= S_IDLE;
      r_rr_ptr <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) r_src_state[i] <= w_src_nxt[i];
      if (w_grant) begin
        r_rr_ptr <= (w_grant_idx == PW'(N_SRC-1)) ? '0 : w_grant_idx + 1'b1;
      end
    end
  end

  // FIFO
  assign w_pop  = (r_out_state == O_SEND) && MAP_IN_AERIN_ACK;
  assign w_load = (r_out_state == O_IDLE) && !w_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LW'(1);
        2'b01:   r_count <= r_count - LW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Output FSM
  always_comb begin
    w_out_nxt = r_out_state;
    case (r_out_state)
      O_IDLE:    if (!w_empty)         w_out_nxt = O_SEND;
      O_SEND:    if (MAP_IN_AERIN_ACK) w_out_nxt = O_RELEASE;
      O_RELEASE: if (!MAP_IN_AERIN_ACK) w_out_nxt = O_IDLE;
      default:   w_out_nxt = O_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_state <= O_IDLE;
      r_out_data  <= '0;
    end else begin
      r_out_state <= w_out_nxt;
      if (w_load) r_out_data <= r_mem[r_rd_ptr];
    end
  end

  assign MAP_IN_AERIN_REQ   = (r_out_state == O_SEND);
  assign MAP_IN_AERIN_EVENT = {r_out_data[AER_WIDTH-1 -: 2], {(AER_WIDTH-2){1'b0}}};
  assign MAP_IN_AERIN_IDX   = r_out_data[AER_WIDTH-3:0];
  assign FIFO_LEVEL         = r_count;
  assign BUSY               = !w_empty || (r_out_state != O_IDLE);

endmodule

// File: tb/tb_aer_in_rr_scheduler.sv
`timescale 1ns/1ps
module tb_aer_in_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  src_req;
  logic [19:0] src_addr;
  logic [1:0]  src_ack;
  logic        map_req;
  logic [9:0]  map_evt;
  logic [7:0]  map_idx;
  logic        map_ack;
  logic [2:0]  level;
  logic        busy;

  int vectors = 0;
  int errors  = 0;

  // mapper model state
  logic       m_hold = 1'b0;
  int         m_rel_delay = 0;
  int         m_rel_cnt;
  logic [9:0] rx_evt [256];
  logic [7:0] rx_idx [256];
  int         rx_cnt = 0;

  // grant log (rising edges of source ACKs)
  int         gnt_log [256];
  int         gnt_cnt = 0;
  logic [1:0] ack_prev = 2'b00;

  always #5 clk = ~clk;

  aer_in_rr_scheduler #(.N_SRC(2), .AER_WIDTH(10), .FIFO_DEPTH(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .SRC_AER_REQ        (src_req),
    .SRC_AER_ADDR       (src_addr),
    .SRC_AER_ACK        (src_ack),
    .MAP_IN_AERIN_REQ   (map_req),
    .MAP_IN_AERIN_EVENT (map_evt),
    .MAP_IN_AERIN_IDX   (map_idx),
    .MAP_IN_AERIN_ACK   (map_ack),
    .FIFO_LEVEL         (level),
    .BUSY               (busy)
  );

  // Mapper: acks on the negedge after REQ is seen, releases m_rel_delay
  // negedges after REQ drops.
  initial begin
    map_ack   = 1'b0;
    m_rel_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        map_ack = 1'b0;
      end else if (!map_ack) begin
        if (map_req && !m_hold) begin
          if (rx_cnt < 256) begin
            rx_evt[rx_cnt] = map_evt;
            rx_idx[rx_cnt] = map_idx;
          end
          rx_cnt++;
          map_ack   = 1'b1;
          m_rel_cnt = 0;
        end
      end else if (!map_req) begin
        if (m_rel_cnt >= m_rel_delay) map_ack = 1'b0;
        else m_rel_cnt++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        if (src_ack[s] === 1'b1 && ack_prev[s] !== 1'b1) begin
          if (gnt_cnt < 256) gnt_log[gnt_cnt] = s;
          gnt_cnt++;
        end
      end
      ack_prev = src_ack;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic src_send(input int s, input logic [9:0] a);
    int t;
    @(negedge clk);
    src_addr[s*10 +: 10] = a;
    src_req[s] = 1'b1;
    t = 0;
    while (src_ack[s] !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    vectors++;
    if (src_ack[s] !== 1'b1) begin
      errors++;
      $display("FAIL src%0d_ack_rise: got %b, expected 1", s, src_ack[s]);
    end
    src_req[s] = 1'b0;
    t = 0;
    while (src_ack[s] !== 1'b0 && t < 300) begin @(negedge clk); t++; end
    vectors++;
    if (src_ack[s] !== 1'b0) begin
      errors++;
      $display("FAIL src%0d_ack_fall: got %b, expected 0", s, src_ack[s]);
    end
  endtask

  task automatic wait_rx(input int n);
    int t = 0;
    while (rx_cnt < n && t < 1000) begin @(negedge clk); t++; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    src_req = 2'b00;
    src_addr = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({src_ack, map_req, map_evt, map_idx, level, busy} !== '0) begin
      errors++;
      $display("FAIL reset_hold: ack=%b req=%b evt=%h idx=%h lvl=%0d busy=%b, expected all 0",
               src_ack, map_req, map_evt, map_idx, level, busy);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({src_ack, map_req, level, busy} !== '0) begin
      errors++;
      $display("FAIL reset_release: ack=%b req=%b lvl=%0d busy=%b, expected all 0",
               src_ack, map_req, level, busy);
    end
  endtask

  task automatic test_single();
    int base = rx_cnt;
    @(negedge clk);
    src_addr[9:0] = 10'h05D;
    src_req[0] = 1'b1;
    #1;
    vectors++;
    if (src_ack[0] !== 1'b0) begin
      errors++; $display("FAIL single_ack_early: got %b, expected 0", src_ack[0]);
    end
    @(posedge clk); #1;
    vectors++;
    if (src_ack[0] !== 1'b1) begin
      errors++; $display("FAIL single_ack_latency: got %b, expected 1", src_ack[0]);
    end
    @(negedge clk);
    src_req[0] = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (map_req !== 1'b1 || map_idx !== 8'h5D || map_evt !== 10'h000) begin
      errors++;
      $display("FAIL single_map_req: req=%b idx=%h evt=%h, expected 1/5d/000", map_req, map_idx, map_evt);
    end
    vectors++;
    if (src_ack[0] !== 1'b0) begin
      errors++; $display("FAIL single_ack_drop: got %b, expected 0", src_ack[0]);
    end
    wait_rx(base + 1);
    repeat (10) @(negedge clk);
    vectors++;
    if (rx_cnt - base !== 1 || rx_idx[base] !== 8'h5D || rx_evt[base] !== 10'h000) begin
      errors++;
      $display("FAIL single_transfer: count=%0d idx=%h evt=%h, expected 1/5d/000",
               rx_cnt - base, rx_idx[base], rx_evt[base]);
    end
    vectors++;
    if (busy !== 1'b0 || level !== 3'd0) begin
      errors++; $display("FAIL single_idle: busy=%b lvl=%0d, expected 0/0", busy, level);
    end
  endtask

  task automatic test_contention();
    int base, gbase, bad;
    do_reset();
    base  = rx_cnt;
    gbase = gnt_cnt;
    fork
      begin
        for (int i = 0; i < 4; i++) src_send(0, {2'b00, 8'h10 + 8'(i)});
      end
      begin
        for (int j = 0; j < 4; j++) src_send(1, {2'b01, 8'h20 + 8'(j)});
      end
    join
    wait_rx(base + 8);
    repeat (5) @(negedge clk);
    vectors++;
    if (gnt_cnt - gbase !== 8 || rx_cnt - base !== 8) begin
      errors++;
      $display("FAIL contention_count: grants=%0d rx=%0d, expected 8/8", gnt_cnt - gbase, rx_cnt - base);
    end
    bad = 0;
    for (int i = 0; i < 8; i++) if (gnt_log[gbase+i] !== (i % 2)) bad++;
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL contention_grant_order: %0d grants out of 0,1,0,1 order, expected 0", bad);
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if ((i % 2) == 0) begin
        if (rx_idx[base+i] !== 8'h10 + 8'(i/2) || rx_evt[base+i] !== 10'h000) bad++;
      end else begin
        if (rx_idx[base+i] !== 8'h20 + 8'(i/2) || rx_evt[base+i] !== 10'h100) bad++;
      end
    end
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL contention_stream: %0d events wrong, expected 0", bad);
    end
  endtask

  task automatic test_backpressure();
    int base = rx_cnt;
    int bad;
    m_hold = 1'b1;
    fork
      begin
        for (int i = 0; i < 6; i++) src_send(0, {2'b00, 8'h30 + 8'(i)});
      end
    join_none
    repeat (30) @(negedge clk);
    vectors++;
    if (level !== 3'd4) begin
      errors++; $display("FAIL bp_level: got %0d, expected 4", level);
    end
    vectors++;
    if (src_ack !== 2'b00 || src_req[0] !== 1'b1) begin
      errors++; $display("FAIL bp_ack_blocked: ack=%b req=%b, expected 00/1", src_ack, src_req[0]);
    end
    vectors++;
    if (map_req !== 1'b1 || map_idx !== 8'h30 || rx_cnt != base) begin
      errors++;
      $display("FAIL bp_head: req=%b idx=%h rx=%0d, expected 1/30/0", map_req, map_idx, rx_cnt - base);
    end
    m_hold = 1'b0;
    wait fork;
    wait_rx(base + 6);
    repeat (5) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 6; i++) if (rx_idx[base+i] !== 8'h30 + 8'(i)) bad++;
    vectors++;
    if (rx_cnt - base !== 6 || bad != 0) begin
      errors++;
      $display("FAIL bp_delivery: rx=%0d wrong=%0d, expected 6/0", rx_cnt - base, bad);
    end
    vectors++;
    if (level !== 3'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_drain: lvl=%0d busy=%b, expected 0/0", level, busy);
    end
  endtask

  task automatic test_slow_release();
    int base = rx_cnt;
    int t, hi_cycles, req_while_ack;
    m_rel_delay = 5;
    fork
      begin
        src_send(0, 10'h041);
        src_send(0, 10'h042);
      end
    join_none
    t = 0;
    while (rx_cnt < base + 1 && t < 200) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    hi_cycles = 0;
    req_while_ack = 0;
    while (map_ack === 1'b1 && hi_cycles < 50) begin
      if (map_req !== 1'b0) req_while_ack++;
      hi_cycles++;
      @(posedge clk); #1;
    end
    vectors++;
    if (req_while_ack != 0 || hi_cycles < 5) begin
      errors++;
      $display("FAIL slow_rel_req_held: req high in %0d of %0d ack-high cycles, expected 0 of >=5",
               req_while_ack, hi_cycles);
    end
    wait fork;
    wait_rx(base + 2);
    repeat (20) @(negedge clk);
    vectors++;
    if (rx_cnt - base !== 2 || rx_idx[base] !== 8'h41 || rx_idx[base+1] !== 8'h42) begin
      errors++;
      $display("FAIL slow_rel_no_dup: rx=%0d idx0=%h idx1=%h, expected 2/41/42",
               rx_cnt - base, rx_idx[base], rx_idx[base+1]);
    end
    m_rel_delay = 0;
  endtask

  task automatic test_reset_mid();
    int base;
    m_hold = 1'b1;
    src_send(0, 10'h051);
    src_send(0, 10'h052);
    @(negedge clk);
    src_addr[19:10] = 10'h053;
    src_req[1] = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (level !== 3'd3 || map_req !== 1'b1 || src_ack[1] !== 1'b1 || map_idx !== 8'h51) begin
      errors++;
      $display("FAIL rstmid_setup: lvl=%0d req=%b ack1=%b idx=%h, expected 3/1/1/51",
               level, map_req, src_ack[1], map_idx);
    end
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if ({src_ack, map_req, map_evt, map_idx, level, busy} !== '0) begin
      errors++;
      $display("FAIL rstmid_async: ack=%b req=%b evt=%h idx=%h lvl=%0d busy=%b, expected all 0",
               src_ack, map_req, map_evt, map_idx, level, busy);
    end
    repeat (2) @(negedge clk);
    base = rx_cnt;
    rst = 1'b1;
    m_hold = 1'b0;
    #1;
    vectors++;
    if (level !== 3'd0 || busy !== 1'b0 || src_ack !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_release: lvl=%0d busy=%b ack=%b, expected 0/0/00", level, busy, src_ack);
    end
    @(posedge clk); #1;
    vectors++;
    if (src_ack[1] !== 1'b1 || level !== 3'd1) begin
      errors++;
      $display("FAIL rstmid_new_req: ack1=%b lvl=%0d, expected 1/1", src_ack[1], level);
    end
    @(negedge clk);
    src_req[1] = 1'b0;
    wait_rx(base + 1);
    repeat (10) @(negedge clk);
    vectors++;
    if (rx_cnt - base !== 1 || rx_idx[base] !== 8'h53) begin
      errors++;
      $display("FAIL rstmid_discard: rx=%0d idx=%h, expected 1/53", rx_cnt - base, rx_idx[base]);
    end
  endtask

  task automatic test_marker();
    int base;
    do_reset();
    base = rx_cnt;
`ifdef AER_SCHED_BARRIER_EN
    fork
      begin
        src_send(0, 10'h200);
        src_send(0, 10'h061);
      end
      begin
        src_send(1, 10'h071);
        src_send(1, 10'h27F);
      end
    join
    wait_rx(base + 3);
    repeat (15) @(negedge clk);
    vectors++;
    if (rx_cnt - base !== 3) begin
      errors++; $display("FAIL barrier_count: got %0d, expected 3", rx_cnt - base);
    end
    vectors++;
    if (rx_idx[base] !== 8'h71 || rx_evt[base] !== 10'h000) begin
      errors++; $display("FAIL barrier_first: idx=%h evt=%h, expected 71/000", rx_idx[base], rx_evt[base]);
    end
    vectors++;
    if (rx_idx[base+1] !== 8'h00 || rx_evt[base+1] !== 10'h200) begin
      errors++; $display("FAIL barrier_marker: idx=%h evt=%h, expected 00/200", rx_idx[base+1], rx_evt[base+1]);
    end
    vectors++;
    if (rx_idx[base+2] !== 8'h61 || rx_evt[base+2] !== 10'h000) begin
      errors++; $display("FAIL barrier_last: idx=%h evt=%h, expected 61/000", rx_idx[base+2], rx_evt[base+2]);
    end
`else
    src_send(0, 10'h266);
    wait_rx(base + 1);
    repeat (10) @(negedge clk);
    vectors++;
    if (rx_cnt - base !== 1 || rx_evt[base] !== 10'h200 || rx_idx[base] !== 8'h66) begin
      errors++;
      $display("FAIL marker_forward: rx=%0d evt=%h idx=%h, expected 1/200/66",
               rx_cnt - base, rx_evt[base], rx_idx[base]);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_slow_release();
    test_reset_mid();
    test_marker();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
